// File: rtl/alu4_arbiter.sv
// Round-robin front end for one shared 4-bit ALU. It registers the granted
// operands, captures the ALU outputs and returns them with the requester id.
module alu4_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [3*NREQ-1:0] req_op,
   input  logic [4*NREQ-1:0] req_a,
   input  logic [4*NREQ-1:0] req_b,
   output logic [2:0]        alu_op,
   output logic [3:0]        alu_a,
   output logic [3:0]        alu_b,
   input  logic [3:0]        alu_result,
   input  logic              alu_carry,
   input  logic              alu_overflow,
   input  logic              alu_zero,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [3:0]        rsp_result,
   output logic [2:0]        rsp_flags,
   output logic              busy
);

   localparam int unsigned OPW  = 3;
   localparam int unsigned DW   = 4;
   localparam int unsigned FLW  = 3;
   localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state_q, state_d;
   logic [PTRW-1:0] rr_q, rr_d;
   logic [OPW-1:0]  op_d;
   logic [DW-1:0]   a_d, b_d;
   logic [IDW-1:0]  id_d;
   logic [DW-1:0]   result_d;
   logic [FLW-1:0]  flags_d;
   logic            valid_d;
   logic            busy_d;
   logic            grant_vld;
   logic [PTRW-1:0] grant_idx;

   // First valid requester at or after rr_q, wrapping; scanned high-to-low so the nearest wins.
   always_comb begin : grant_scan
      int unsigned idx;
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         idx = 32'(rr_q) + unsigned'(k);
         if (idx >= NREQ) idx = idx - NREQ;
         if (req_valid[idx[PTRW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = idx[PTRW-1:0];
         end
      end
   end

   always_comb begin : next_state
      state_d   = state_q;
      rr_d      = rr_q;
      op_d      = alu_op;
      a_d       = alu_a;
      b_d       = alu_b;
      id_d      = rsp_id;
      result_d  = rsp_result;
      flags_d   = rsp_flags;
      valid_d   = rsp_valid;
      req_ready = '0;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               req_ready[grant_idx] = 1'b1;
               op_d    = req_op[OPW*grant_idx +: OPW];
               a_d     = req_a[DW*grant_idx +: DW];
               b_d     = req_b[DW*grant_idx +: DW];
               id_d    = IDW'(grant_idx);
               rr_d    = (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + PTRW'(1);
               state_d = EXEC;
            end
         end
         EXEC: begin
            result_d = alu_result;
            flags_d  = {alu_carry, alu_overflow, alu_zero};
            valid_d  = 1'b1;
            state_d  = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_q       <= '0;
         alu_op     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         alu_op     <= op_d;
         alu_a      <= a_d;
         alu_b      <= b_d;
         rsp_id     <= id_d;
         rsp_result <= result_d;
         rsp_flags  <= flags_d;
         rsp_valid  <= valid_d;
         busy       <= busy_d;
      end
   end

endmodule

// File: tb/tb_alu4_arbiter.sv
// Bench for alu4_arbiter: the bench plays the shared ALU and keeps a
// transaction-level model of grants and responses checked every cycle.
module tb_alu4_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk, rst_n;
   logic [NREQ-1:0]   req_valid, req_ready;
   logic [3*NREQ-1:0] req_op;
   logic [4*NREQ-1:0] req_a, req_b;
   logic [2:0]        alu_op;
   logic [3:0]        alu_a, alu_b, alu_result;
   logic              alu_carry, alu_overflow, alu_zero;
   logic              rsp_valid, rsp_ready, busy;
   logic [IDW-1:0]    rsp_id;
   logic [3:0]        rsp_result;
   logic [2:0]        rsp_flags;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int g_idx[$];
   int g_cyc[$];
   int exp_ord[5] = '{0, 1, 2, 3, 0};

   alu4_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_carry(alu_carry),
      .alu_overflow(alu_overflow), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // The shared ALU: {result, carry, overflow, zero}; compares set zero on a==b.
   function automatic logic [6:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [4:0] s;
      logic [3:0] r;
      logic c, v, z;
      s = '0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
         3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
         3'd2: r = ~a;
         3'd3: r = a & b;
         3'd4: r = a | b;
         3'd5: r = a ^ b;
         3'd6: r = ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
         default: r = (a == b) ? 4'd1 : 4'd0;
      endcase
      z = (op == 3'd6 || op == 3'd7) ? (a == b) : (r == 4'd0);
      return {r, c, v, z};
   endfunction

   assign {alu_result, alu_carry, alu_overflow, alu_zero} = alu_f(alu_op, alu_a, alu_b);

   function automatic int pick(input int ptr, input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++)
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [31:0] onehot(input int g);
      logic [31:0] r;
      r = '0;
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // Transaction model: one slot in flight, response visible one edge after accept.
   logic       m_have = 1'b0;
   int         m_age  = 0;
   int         m_ptr  = 0;
   int         m_id   = 0;
   int         m_g;
   logic [2:0] m_op   = '0;
   logic [3:0] m_a    = '0, m_b = '0, m_res = '0;
   logic [2:0] m_flg  = '0;

   always_comb m_g = pick(m_ptr, req_valid);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_have <= 1'b0;
         m_age  <= 0;
         m_ptr  <= 0;
      end else if (!m_have) begin
         if (m_g >= 0) begin
            m_have <= 1'b1;
            m_age  <= 0;
            m_id   <= m_g;
            m_ptr  <= (m_g + 1) % NREQ;
            m_op   <= req_op[3*m_g +: 3];
            m_a    <= req_a[4*m_g +: 4];
            m_b    <= req_b[4*m_g +: 4];
            {m_res, m_flg} <= alu_f(req_op[3*m_g +: 3], req_a[4*m_g +: 4], req_b[4*m_g +: 4]);
         end
      end else if (m_age == 0) begin
         m_age <= 1;
      end else if (rsp_ready) begin
         m_have <= 1'b0;
      end
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         chk("rst_valid", 32'(rsp_valid), 32'(0));
         chk("rst_busy", 32'(busy), 32'(0));
         chk("rst_id", 32'(rsp_id), 32'(0));
         chk("rst_result", 32'(rsp_result), 32'(0));
         chk("rst_flags", 32'(rsp_flags), 32'(0));
         chk("rst_alu", 32'({alu_op, alu_a, alu_b}), 32'(0));
      end else begin
         chk("req_ready", 32'(req_ready), m_have ? 32'(0) : onehot(m_g));
         chk("busy", 32'(busy), 32'(m_have));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_have && m_age == 1));
         if (m_have && m_age == 1) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_result", 32'(rsp_result), 32'(m_res));
            chk("rsp_flags", 32'(rsp_flags), 32'(m_flg));
         end
         if (m_have && m_age == 0)
            chk("alu_operands", 32'({alu_op, alu_a, alu_b}), 32'({m_op, m_a, m_b}));
         for (int i = 0; i < NREQ; i++)
            if (req_ready[i]) begin
               g_idx.push_back(i);
               g_cyc.push_back(cyc);
            end
      end
   end

   task automatic set_req(input int i, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      req_op[3*i +: 3] = op;
      req_a[4*i +: 4]  = a;
      req_b[4*i +: 4]  = b;
   endtask

   task automatic grant_of(input logic [NREQ-1:0] v, output int g);
      int n;
      g = -1;
      n = 0;
      @(posedge clk); #1 req_valid = v;
      while (g < 0 && n < 30) begin
         @(negedge clk);
         n++;
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
      end
      if (g < 0) fail_now("grant_timeout");
      @(posedge clk); #1 req_valid = '0;
   endtask

   task automatic issue(input int i, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      int g;
      logic [NREQ-1:0] v;
      v = '0;
      v[i] = 1'b1;
      set_req(i, op, a, b);
      grant_of(v, g);
      chk("grant_id", 32'(g), 32'(i));
   endtask

   task automatic wait_rsp(input int id, input logic [3:0] res, input logic [2:0] flg);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 20);
      if (!rsp_valid) fail_now("rsp_timeout");
      else begin
         chk("lit_id", 32'(rsp_id), 32'(id));
         chk("lit_result", 32'(rsp_result), 32'(res));
         chk("lit_flags", 32'(rsp_flags), 32'(flg));
         chk("lit_latency", 32'(n), 32'(2));
      end
   endtask

   task automatic reset_dut();
      req_valid = '0;
      @(negedge clk); #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(rsp_valid), 32'(0));
      chk("async_busy", 32'(busy), 32'(0));
      @(negedge clk); #2 rst_n = 1'b1;
   endtask

   initial begin
      int g;
      rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      #21;
      chk("init_valid", 32'(rsp_valid), 32'(0));
      chk("init_busy", 32'(busy), 32'(0));
      chk("init_ready", 32'(req_ready), 32'(0));
      #1 rst_n = 1'b1;

      // Single add from requester 2, then xor from 3, then wrap with 0 and 3 valid.
      issue(2, 3'b000, 4'b0111, 4'b0001);
      wait_rsp(2, 4'b1000, 3'b010);
      issue(3, 3'b101, 4'b1100, 4'b1010);
      wait_rsp(3, 4'b0110, 3'b000);
      set_req(0, 3'b100, 4'b0001, 4'b0010);
      set_req(3, 3'b011, 4'b1111, 4'b0101);
      grant_of(4'b1001, g);
      chk("wrap_grant", 32'(g), 32'(0));
      wait_rsp(0, 4'b0011, 3'b000);

      // Sub then signed less-than on the same operands.
      issue(0, 3'b001, 4'b0011, 4'b0101);
      wait_rsp(0, 4'b1110, 3'b100);
      issue(0, 3'b110, 4'b0011, 4'b0101);
      wait_rsp(0, 4'b0001, 3'b000);

      // All requesters continuously valid from a fresh pointer.
      reset_dut();
      for (int i = 0; i < NREQ; i++) set_req(i, 3'(i), 4'(i + 3), 4'(2 * i + 1));
      g_idx.delete();
      g_cyc.delete();
      @(posedge clk); #1 req_valid = '1;
      repeat (16) @(negedge clk);
      @(posedge clk); #1 req_valid = '0;
      chk("rr_count", 32'(g_idx.size() >= 5), 32'(1));
      if (g_idx.size() >= 5) begin
         for (int k = 0; k < 5; k++) chk("rr_order", 32'(g_idx[k]), 32'(exp_ord[k]));
         for (int k = 1; k < 5; k++) chk("rr_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'(3));
      end
      repeat (4) @(negedge clk);

      // Backpressure on an eq response while another requester waits.
      reset_dut();
      rsp_ready = 1'b0;
      issue(1, 3'b111, 4'd5, 4'd5);
      wait_rsp(1, 4'b0001, 3'b001);
      set_req(0, 3'b000, 4'd1, 4'd2);
      @(posedge clk); #1 req_valid = 4'b0001;
      repeat (5) begin
         @(negedge clk);
         chk("stall_ready", 32'(req_ready), 32'(0));
         chk("stall_valid", 32'(rsp_valid), 32'(1));
         chk("stall_result", 32'(rsp_result), 32'(1));
         chk("stall_zero", 32'(rsp_flags[0]), 32'(1));
      end
      @(posedge clk); #1 rsp_ready = 1'b1; req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      chk("drain_valid", 32'(rsp_valid), 32'(0));
      chk("drain_busy", 32'(busy), 32'(0));

      // Reset while a response is held: outputs clear at once, pointer restarts at 0.
      rsp_ready = 1'b0;
      issue(2, 3'b000, 4'd1, 4'd1);
      wait_rsp(2, 4'b0010, 3'b000);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(rsp_valid), 32'(0));
      chk("mid_rst_busy", 32'(busy), 32'(0));
      chk("mid_rst_result", 32'(rsp_result), 32'(0));
      @(negedge clk); #2 rst_n = 1'b1;
      rsp_ready = 1'b1;
      set_req(0, 3'b010, 4'b0101, 4'd0);
      set_req(3, 3'b000, 4'd2, 4'd2);
      grant_of(4'b1001, g);
      chk("post_rst_grant", 32'(g), 32'(0));
      wait_rsp(0, 4'b1010, 3'b000);
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
